// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, sprite sizes and obstacle FSM states
// Purpose: constants and types common to the game datapath blocks.
package game_pkg;

   localparam int SCREEN_W = 640;   // visible width, pixels
   localparam int SCREEN_H = 480;   // visible height; y == SCREEN_H means parked
   localparam int OBJ_W    = 32;    // obstacle sprite width
   localparam int OBJ_H    = 32;    // obstacle sprite height
   localparam int PLY_W    = 32;    // player sprite width
   localparam int PLY_H    = 32;    // player sprite height

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FALL = 2'd1,
      HIT  = 2'd2
   } obstacle_state_t;

endpackage

// File: rtl/vsync_tick.sv
// rtl/vsync_tick.sv - vsync synchronizer and one-cycle frame tick on its falling edge
// Purpose: turns the asynchronous VGA vertical sync into a single-cycle frame tick.
// Ports:
//   i_clk    in  1  system clock
//   i_rst_n  in  1  asynchronous active-low reset
//   i_vsync  in  1  raw VGA_VS, asynchronous; low pulse marks a frame boundary
//   o_tick   out 1  one-cycle pulse, high 3 clock edges after vsync falls
module vsync_tick (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vsync,
   output logic o_tick
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_tick;

   // Sync flops reset high (vsync idle level) so leaving reset never fakes an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_tick  <= 1'b0;
      end else begin
         r_sync1 <= i_vsync;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_tick  <= r_prev & ~r_sync2;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/obstacle_motion.sv
// rtl/obstacle_motion.sv - single falling obstacle: spawn, per-frame motion, exit and hit detection
// Purpose: spawns one obstacle at a requested column, moves it down each frame, reports its
//          top-left position, pulses passed when it leaves the screen and latches a collision
//          flag when it overlaps the player box.
// Ports:
//   CLOCK_50       in  1   system clock
//   reset          in  1   asynchronous active-low reset
//   vsync          in  1   raw VGA_VS, low pulse marks a frame boundary
//   spawn_trigger  in  1   one-cycle spawn request
//   spawn_x        in  10  requested obstacle column
//   step_y         in  3   pixels moved per frame (0 = frozen)
//   restart        in  1   one-cycle pulse, returns to IDLE and clears the hit
//   player_x       in  10  player top-left x
//   player_y       in  10  player top-left y
//   obstacle_x     out 10  obstacle top-left x
//   obstacle_y     out 10  obstacle top-left y
//   active         out 1   high while falling
//   passed         out 1   one-cycle pulse when the obstacle exits the bottom
//   collision      out 1   sticky hit flag
module obstacle_motion
   import game_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       vsync,
   input  logic       spawn_trigger,
   input  logic [9:0] spawn_x,
   input  logic [2:0] step_y,
   input  logic       restart,
   input  logic [9:0] player_x,
   input  logic [9:0] player_y,
   output logic [9:0] obstacle_x,
   output logic [9:0] obstacle_y,
   output logic       active,
   output logic       passed,
   output logic       collision
);

   localparam logic [9:0]  X_MAX  = 10'(SCREEN_W - OBJ_W);
   localparam logic [9:0]  Y_PARK = 10'(SCREEN_H);
   localparam logic [10:0] H_11   = 11'(SCREEN_H);

   obstacle_state_t r_state, w_state_nx;
   logic [9:0] r_obs_x, w_obs_x_nx;
   logic [9:0] r_obs_y, w_obs_y_nx;
   logic       r_active, r_passed, w_passed_nx;
   logic       r_collision, w_collision_nx;

   logic        w_tick;
   logic [10:0] w_ny;
   logic [10:0] w_ox, w_px, w_py;
   logic        w_overlap;

   vsync_tick u_vsync_tick (
      .i_clk   (CLOCK_50),
      .i_rst_n (reset),
      .i_vsync (vsync),
      .o_tick  (w_tick)
   );

   // All arithmetic in 11 bits so y + step and coordinate + size never wrap.
   assign w_ny = {1'b0, r_obs_y} + {8'd0, step_y};
   assign w_ox = {1'b0, r_obs_x};
   assign w_px = {1'b0, player_x};
   assign w_py = {1'b0, player_y};

   // Strict AABB overlap against the candidate position; touching edges do not count.
   assign w_overlap = (w_ox < w_px + 11'(PLY_W)) && (w_px < w_ox + 11'(OBJ_W)) &&
                      (w_ny < w_py + 11'(PLY_H)) && (w_py < w_ny + 11'(OBJ_H));

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_obs_x     <= '0;
         r_obs_y     <= Y_PARK;
         r_active    <= 1'b0;
         r_passed    <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_obs_x     <= w_obs_x_nx;
         r_obs_y     <= w_obs_y_nx;
         r_active    <= (w_state_nx == FALL);
         r_passed    <= w_passed_nx;
         r_collision <= w_collision_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_obs_x_nx     = r_obs_x;
      w_obs_y_nx     = r_obs_y;
      w_passed_nx    = 1'b0;
      w_collision_nx = r_collision;

      // restart overrides everything else in every state, including a same-cycle spawn.
      if (restart) begin
         w_state_nx     = IDLE;
         w_obs_y_nx     = Y_PARK;
         w_collision_nx = 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               // A tick coinciding with the spawn is simply not looked at here.
               if (spawn_trigger) begin
                  w_obs_x_nx = (spawn_x > X_MAX) ? X_MAX : spawn_x;
                  w_obs_y_nx = '0;
                  w_state_nx = FALL;
               end
            end
            FALL: begin
               if (w_tick) begin
                  if (w_ny >= H_11) begin
                     w_obs_y_nx  = Y_PARK;
                     w_passed_nx = 1'b1;
                     w_state_nx  = IDLE;
                  end else begin
                     w_obs_y_nx = w_ny[9:0];
                     if (w_overlap) begin
                        w_collision_nx = 1'b1;
                        w_state_nx     = HIT;
                     end
                  end
               end
            end
            HIT: begin
               // Frozen until restart.
            end
            default: begin
               w_state_nx = IDLE;
               w_obs_y_nx = Y_PARK;
            end
         endcase
      end
   end

   assign obstacle_x = r_obs_x;
   assign obstacle_y = r_obs_y;
   assign active     = r_active;
   assign passed     = r_passed;
   assign collision  = r_collision;

endmodule

// File: tb/tb_obstacle_motion.sv
// tb/tb_obstacle_motion.sv - self-checking bench for obstacle_motion
module tb_obstacle_motion;

   localparam int W   = 640;
   localparam int H   = 480;
   localparam int OW  = 32;
   localparam int OH  = 32;
   localparam int PW  = 32;
   localparam int PH  = 32;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b0;
   logic       vsync = 1'b1;
   logic       spawn_trigger = 1'b0;
   logic [9:0] spawn_x = '0;
   logic [2:0] step_y = '0;
   logic       restart = 1'b0;
   logic [9:0] player_x = 10'd500;
   logic [9:0] player_y = 10'd400;
   logic [9:0] obstacle_x, obstacle_y;
   logic       active, passed, collision;

   obstacle_motion dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .vsync         (vsync),
      .spawn_trigger (spawn_trigger),
      .spawn_x       (spawn_x),
      .step_y        (step_y),
      .restart       (restart),
      .player_x      (player_x),
      .player_y      (player_y),
      .obstacle_x    (obstacle_x),
      .obstacle_y    (obstacle_y),
      .active        (active),
      .passed        (passed),
      .collision     (collision)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_chk  = 0;
   int n_fail = 0;
   int pass_seen = 0;

   // Reference model: the obstacle as a game object (0 idle, 1 falling, 2 hit).
   int m_state, m_x, m_y, m_passed, m_coll;
   int vq[$];   // last four vsync samples, oldest first

   typedef struct {
      int sx;
      int ex;
   } clamp_vec_t;
   clamp_vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state = 0; m_x = 0; m_y = H; m_passed = 0; m_coll = 0;
      vq = '{1, 1, 1, 1};
   endfunction

   function automatic bit boxes_touch(int ox, int oy, int px, int py);
      return (ox < px + PW) && (px < ox + OW) && (oy < py + PH) && (py < oy + OH);
   endfunction

   // A frame boundary seen on the input reaches the motion logic four samples later.
   function automatic void model_edge();
      bit tick;
      int ny;
      tick = (vq[0] == 1) && (vq[1] == 0);
      vq.push_back(int'(vsync));
      vq.delete(0);
      m_passed = 0;
      if (restart) begin
         m_state = 0; m_y = H; m_coll = 0;
      end else if (m_state == 0) begin
         if (spawn_trigger) begin
            m_x = (int'(spawn_x) > W - OW) ? W - OW : int'(spawn_x);
            m_y = 0;
            m_state = 1;
         end
      end else if (m_state == 1 && tick) begin
         ny = m_y + int'(step_y);
         if (ny >= H) begin
            m_y = H; m_passed = 1; m_state = 0;
         end else begin
            m_y = ny;
            if (boxes_touch(m_x, ny, int'(player_x), int'(player_y))) begin
               m_coll = 1; m_state = 2;
            end
         end
      end
   endfunction

   task automatic check_all();
      chk("obstacle_x", 32'(obstacle_x), 32'(m_x));
      chk("obstacle_y", 32'(obstacle_y), 32'(m_y));
      chk("active",     32'(active),     32'(m_state == 1));
      chk("passed",     32'(passed),     32'(m_passed));
      chk("collision",  32'(collision),  32'(m_coll));
   endtask

   // Inputs are driven at the falling edge; outputs are compared at the next falling edge.
   task automatic step();
      @(posedge CLOCK_50);
      if (reset) model_edge();
      @(negedge CLOCK_50);
      if (passed === 1'b1) pass_seen++;
      if (reset) check_all();
   endtask

   task automatic do_spawn(input int x);
      spawn_trigger = 1'b1;
      spawn_x = 10'(x);
      step();
      spawn_trigger = 1'b0;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   task automatic frame();
      vsync = 1'b0;
      repeat (2) step();
      vsync = 1'b1;
      repeat (6) step();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, nfr;

      tbl[0] = '{0, 0};
      tbl[1] = '{100, 100};
      tbl[2] = '{607, 607};
      tbl[3] = '{608, 608};
      tbl[4] = '{609, 608};
      tbl[5] = '{630, 608};
      tbl[6] = '{1023, 608};

      // Reset state
      reset = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_x", 32'(obstacle_x), 32'd0);
      chk("rst_y", 32'(obstacle_y), 32'd480);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_passed", 32'(passed), 32'd0);
      chk("rst_collision", 32'(collision), 32'd0);
      reset = 1'b1;
      model_reset();
      repeat (5) step();

      // Spawn column clamping
      player_x = 10'd0; player_y = 10'd400;
      for (int i = 0; i < 7; i++) begin
         do_restart();
         do_spawn(tbl[i].sx);
         chk("clamp_x", 32'(obstacle_x), 32'(tbl[i].ex));
         chk("clamp_y", 32'(obstacle_y), 32'd0);
         chk("clamp_active", 32'(active), 32'd1);
      end

      // Full fall with exit pulse
      do_restart();
      player_x = 10'd500; player_y = 10'd400; step_y = 3'd4;
      do_spawn(100);
      frame();
      chk("fall_first_y", 32'(obstacle_y), 32'd4);
      p0 = pass_seen;
      nfr = 0;
      while (active === 1'b1 && nfr < 200) begin
         frame();
         nfr++;
      end
      chk("fall_frames", 32'(nfr), 32'd119);
      chk("fall_passed_count", 32'(pass_seen - p0), 32'd1);
      chk("fall_end_y", 32'(obstacle_y), 32'd480);
      chk("fall_end_active", 32'(active), 32'd0);

      // Asynchronous reset mid-fall at y=100
      do_spawn(100);
      repeat (25) frame();
      chk("pre_reset_y", 32'(obstacle_y), 32'd100);
      #3 reset = 1'b0;
      #1;
      chk("async_rst_y", 32'(obstacle_y), 32'd480);
      chk("async_rst_active", 32'(active), 32'd0);
      chk("async_rst_collision", 32'(collision), 32'd0);
      chk("async_rst_passed", 32'(passed), 32'd0);
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b1;
      model_reset();
      repeat (4) step();

      // Collision against player at (100,40)
      player_x = 10'd100; player_y = 10'd40; step_y = 3'd4;
      do_spawn(110);
      repeat (3) frame();
      chk("hit_y", 32'(obstacle_y), 32'd12);
      chk("hit_collision", 32'(collision), 32'd1);
      chk("hit_active", 32'(active), 32'd0);
      repeat (2) frame();
      chk("hit_frozen_y", 32'(obstacle_y), 32'd12);
      do_spawn(300);
      chk("hit_ignores_spawn", 32'(obstacle_x), 32'd110);
      do_restart();
      chk("hit_restart_collision", 32'(collision), 32'd0);
      chk("hit_restart_y", 32'(obstacle_y), 32'd480);

      // Spawn ignored while falling; restart beats spawn in IDLE
      player_x = 10'd500; player_y = 10'd400;
      do_spawn(200);
      repeat (5) frame();
      chk("fall_y20", 32'(obstacle_y), 32'd20);
      do_spawn(50);
      chk("fall_spawn_ignored", 32'(obstacle_x), 32'd200);
      do_restart();
      restart = 1'b1;
      do_spawn(60);
      restart = 1'b0;
      chk("restart_wins_active", 32'(active), 32'd0);
      chk("restart_wins_y", 32'(obstacle_y), 32'd480);

      // Spawn coinciding with a tick; tick latency and one tick per frame
      repeat (4) step();
      step_y = 3'd5;
      vsync = 1'b0;
      repeat (3) step();
      do_spawn(300);
      chk("spawn_tick_y", 32'(obstacle_y), 32'd0);
      repeat (10) step();
      chk("held_low_y", 32'(obstacle_y), 32'd0);
      vsync = 1'b1;
      repeat (3) step();
      vsync = 1'b0;
      repeat (3) step();
      chk("tick_not_yet_y", 32'(obstacle_y), 32'd0);
      step();
      chk("tick_latency_y", 32'(obstacle_y), 32'd5);
      repeat (6) step();
      chk("one_tick_per_frame_y", 32'(obstacle_y), 32'd5);
      vsync = 1'b1;
      repeat (4) step();

      // step_y = 0 freezes motion but still tests overlap
      step_y = 3'd0;
      player_x = 10'd300; player_y = 10'd20;
      frame();
      chk("zero_step_y", 32'(obstacle_y), 32'd5);
      chk("zero_step_hit", 32'(collision), 32'd1);
      do_restart();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) begin
            player_x = 10'($urandom_range(0, 660));
            player_y = 10'($urandom_range(0, 500));
         end
         vsync = ($urandom_range(0, 4) != 0);
         spawn_trigger = ($urandom_range(0, 15) == 0);
         spawn_x = 10'($urandom);
         step_y = 3'($urandom);
         restart = ($urandom_range(0, 79) == 0);
         step();
      end
      spawn_trigger = 1'b0;
      restart = 1'b0;
      vsync = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
